// File: rtl/gate_tt_pkg.sv
// Shared types and limits for the gate truth-table sweep controller.
// Imported by the sequencer and by anything that decodes its state.
package gate_tt_pkg;

  localparam int TT_MAX_N_IN   = 4;
  localparam int TT_MAX_SETTLE = 15;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } tt_state_e;

endpackage

// File: rtl/gate_tt_sequencer.sv
// Truth-table sweep controller: walks every input pattern of one gate,
// captures its output per pattern and compares against an expected table.
module gate_tt_sequencer
  import gate_tt_pkg::tt_state_e,
         gate_tt_pkg::IDLE,
         gate_tt_pkg::SAMPLE,
         gate_tt_pkg::FINISH,
         gate_tt_pkg::TT_MAX_N_IN,
         gate_tt_pkg::TT_MAX_SETTLE;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      gate_in,
  input  logic                 gate_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   tt,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int              NPAT      = 2**N_IN;
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST      = '1;

  if (N_IN < 1 || N_IN > TT_MAX_N_IN) begin : g_bad_n_in
    $error("gate_tt_sequencer: N_IN out of range");
  end
  if (SETTLE < 0 || SETTLE > TT_MAX_SETTLE) begin : g_bad_settle
    $error("gate_tt_sequencer: SETTLE out of range");
  end

  tt_state_e       state_q;
  tt_state_e       state_d;
  logic [3:0]      cnt_q;
  logic [N_IN-1:0] idx_q;
  logic [NPAT-1:0] exp_q;
  logic            fail_q;
  logic            accept;
  logic            last_pat;
  logic            mismatch;

  assign accept   = start && !abort;
  assign last_pat = (idx_q == LAST);
  assign mismatch = (gate_out != exp_q[idx_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = gate_tt_pkg::SETTLE;
      end
      gate_tt_pkg::SETTLE: begin
        if (abort)            state_d = IDLE;
        else if (cnt_q == '0) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort)         state_d = IDLE;
        else if (last_pat) state_d = FINISH;
        else               state_d = gate_tt_pkg::SETTLE;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // An abort landing in FINISH cancels the completion pulse.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FINISH) && !abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      exp_q    <= '0;
      fail_q   <= 1'b0;
      gate_in  <= '0;
      tt       <= '0;
      pass     <= 1'b0;
      fail_idx <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            exp_q    <= expected;
            tt       <= '0;
            pass     <= 1'b0;
            fail_idx <= '0;
            fail_q   <= 1'b0;
            idx_q    <= '0;
            gate_in  <= '0;
            cnt_q    <= SETTLE_LD;
          end
        end
        gate_tt_pkg::SETTLE: begin
          if (abort) begin
            gate_in <= '0;
            pass    <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            gate_in <= '0;
            pass    <= 1'b0;
          end else begin
            tt[idx_q] <= gate_out;
            if (mismatch && !fail_q) begin
              fail_idx <= idx_q;
              fail_q   <= 1'b1;
            end
            // Verdict includes the final pattern's own comparison.
            if (last_pat) begin
              pass <= !(fail_q || mismatch);
            end else begin
              idx_q   <= idx_q + 1'b1;
              gate_in <= idx_q + 1'b1;
              cnt_q   <= SETTLE_LD;
            end
          end
        end
        FINISH: begin
          gate_in <= '0;
          if (abort) pass <= 1'b0;
        end
        default: begin
          gate_in <= '0;
        end
      endcase
    end
  end

endmodule
